// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock datapath.
// Holds the alarm state enum, time field widths and tone timing defaults.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RINGING,
      ST_SNOOZE,
      ST_DONE
   } alarm_state_t;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int CLK_HZ = 100000000;

   // 440 Hz tone: half period in clk cycles
   localparam int TONE_HALF_DEF = CLK_HZ / 880;
   // 0.5 s beep on / off phase
   localparam int BEEP_HALF_DEF = CLK_HZ / 2;

endpackage

// File: rtl/alarm_sequencer_tone_gen.sv
// tone_gen: square-wave tone gated by a slower beep on/off envelope.
// Ports: clk, reset (sync, high), enable (count), restart (both phases
// back to 1, counters 0), gated (tone & beep_on).
module tone_gen
   import clock_pkg::*;
#(
   parameter int TONE_HALF = TONE_HALF_DEF,
   parameter int BEEP_HALF = BEEP_HALF_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic restart,
   output logic gated
);

   localparam int TW = $clog2(TONE_HALF + 1);
   localparam int BW = $clog2(BEEP_HALF + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TONE_HALF - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BEEP_HALF - 1);

   logic [TW-1:0] r_tone_cnt;
   logic [BW-1:0] r_beep_cnt;
   logic          r_tone;
   logic          r_beep_on;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tone_cnt <= '0;
         r_beep_cnt <= '0;
         r_tone     <= 1'b0;
         r_beep_on  <= 1'b0;
      end else if (restart) begin
         r_tone_cnt <= '0;
         r_beep_cnt <= '0;
         r_tone     <= 1'b1;
         r_beep_on  <= 1'b1;
      end else if (enable) begin
         if (r_tone_cnt == T_LAST) begin
            r_tone_cnt <= '0;
            r_tone     <= ~r_tone;
         end else begin
            r_tone_cnt <= r_tone_cnt + TW'(1);
         end
         if (r_beep_cnt == B_LAST) begin
            r_beep_cnt <= '0;
            r_beep_on  <= ~r_beep_on;
         end else begin
            r_beep_cnt <= r_beep_cnt + BW'(1);
         end
      end
   end

   assign gated = r_tone & r_beep_on;

endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: detects the alarm time, runs ring/snooze/timeout and
// drives the speaker. Inputs: clk, reset, tick_1hz, time, alarm time,
// enable/edit levels, snooze/stop buttons. Outputs: speaker, ringing,
// snoozed, snooze_cnt.
module alarm_sequencer
   import clock_pkg::*;
#(
   parameter int TONE_HALF      = TONE_HALF_DEF,
   parameter int BEEP_HALF      = BEEP_HALF_DEF,
   parameter int SNOOZE_S       = 540,
   parameter int RING_TIMEOUT_S = 60,
   parameter int MAX_SNOOZE     = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick_1hz,
   input  logic [HOUR_W-1:0] hours,
   input  logic [MIN_W-1:0]  minutes,
   input  logic [HOUR_W-1:0] alarm_hours,
   input  logic [MIN_W-1:0]  alarm_minutes,
   input  logic              alarm_enable,
   input  logic              edit_active,
   input  logic              snooze_btn,
   input  logic              stop_btn,
   output logic              speaker,
   output logic              ringing,
   output logic              snoozed,
   output logic [1:0]        snooze_cnt
);

   localparam int RT_W = $clog2(RING_TIMEOUT_S + 1);
   localparam int ST_W = $clog2(SNOOZE_S + 1);
   localparam logic [RT_W-1:0] RT_MAX  = RT_W'(RING_TIMEOUT_S);
   localparam logic [RT_W-1:0] RT_LAST = RT_W'(RING_TIMEOUT_S - 1);
   localparam logic [ST_W-1:0] ST_LOAD = ST_W'(SNOOZE_S);
   localparam logic [1:0]      MAX_CNT = 2'(MAX_SNOOZE);

   alarm_state_t    r_state, w_next;
   logic            w_match, w_trig, r_match_q;
   logic            r_snz_q, r_stop_q, r_snz_edge, r_stop_edge;
   logic [RT_W-1:0] r_ring_tmr;
   logic [ST_W-1:0] r_snz_tmr;
   logic [1:0]      r_snz_cnt;
   logic            r_speaker;
   logic            w_enter, w_take, w_cnt_clr;
   logic            w_ring, w_gated;

   assign w_match = alarm_enable & ~edit_active
                  & (hours == alarm_hours)
                  & (minutes == alarm_minutes);
   assign w_trig  = w_match & ~r_match_q;
   assign w_ring  = (r_state == ST_RINGING);

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_enter   = 1'b0;
      w_take    = 1'b0;
      w_cnt_clr = 1'b0;
      if (!alarm_enable) begin
         w_next    = ST_IDLE;
         w_cnt_clr = 1'b1;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_trig) begin
                  w_next    = ST_RINGING;
                  w_enter   = 1'b1;
                  w_cnt_clr = 1'b1;
               end
            end
            ST_RINGING: begin
               // stop beats snooze; a refused snooze falls to the timer
               if (r_stop_edge) begin
                  w_next = ST_DONE;
               end else if (r_snz_edge && r_snz_cnt < MAX_CNT) begin
                  w_next = ST_SNOOZE;
                  w_take = 1'b1;
               end else if (tick_1hz && r_ring_tmr == RT_LAST) begin
                  w_next = ST_DONE;
               end
            end
            ST_SNOOZE: begin
               if (r_stop_edge) begin
                  w_next = ST_DONE;
               end else if (tick_1hz && r_snz_tmr <= ST_W'(1)) begin
                  w_next  = ST_RINGING;
                  w_enter = 1'b1;
               end
            end
            ST_DONE: begin
               if (!w_match) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_match_q   <= 1'b0;
         r_snz_q     <= 1'b0;
         r_stop_q    <= 1'b0;
         r_snz_edge  <= 1'b0;
         r_stop_edge <= 1'b0;
         r_ring_tmr  <= '0;
         r_snz_tmr   <= '0;
         r_snz_cnt   <= '0;
         r_speaker   <= 1'b0;
      end else begin
         r_match_q   <= w_match;
         r_snz_q     <= snooze_btn;
         r_stop_q    <= stop_btn;
         r_snz_edge  <= snooze_btn & ~r_snz_q;
         r_stop_edge <= stop_btn & ~r_stop_q;
         if (w_enter)
            r_ring_tmr <= '0;
         else if (w_ring && tick_1hz && r_ring_tmr != RT_MAX)
            r_ring_tmr <= r_ring_tmr + RT_W'(1);
         if (w_take)
            r_snz_tmr <= ST_LOAD;
         else if (r_state == ST_SNOOZE && tick_1hz && r_snz_tmr != '0)
            r_snz_tmr <= r_snz_tmr - ST_W'(1);
         if (w_cnt_clr)   r_snz_cnt <= '0;
         else if (w_take) r_snz_cnt <= r_snz_cnt + 2'd1;
         r_speaker <= w_ring & w_gated;
      end
   end

   tone_gen #(
      .TONE_HALF (TONE_HALF),
      .BEEP_HALF (BEEP_HALF)
   ) u_tone (
      .clk     (clk),
      .reset   (reset),
      .enable  (w_ring),
      .restart (w_enter),
      .gated   (w_gated)
   );

   assign speaker    = r_speaker;
   assign ringing    = w_ring;
   assign snoozed    = (r_state == ST_SNOOZE);
   assign snooze_cnt = r_snz_cnt;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed scenarios then random stimulus,
// every cycle compared against a behavioural model of the alarm rules.
module tb_alarm_sequencer;

   localparam int TH   = 4;
   localparam int BH   = 16;
   localparam int SNS  = 3;
   localparam int RTO  = 5;
   localparam int MAXS = 2;

   localparam int M_IDLE = 0;
   localparam int M_RING = 1;
   localparam int M_SNZ  = 2;
   localparam int M_DONE = 3;

   logic       clk = 1'b0;
   logic       reset, tick_1hz, en, ed, sb, st;
   logic [4:0] h, ah;
   logic [5:0] m, am;
   logic       speaker, ringing, snoozed;
   logic [1:0] snooze_cnt;

   int checks = 0;
   int errors = 0;
   int tick_ctr = 0;
   bit tick_auto = 1;

   int md = M_IDLE, m_cnt = 0, m_rt = 0, m_sl = 0, m_age = 0;
   bit m_pm = 0, m_sbp = 0, m_stp = 0, m_sbe = 0, m_ste = 0, m_spk = 0;

   always #5 clk = ~clk;

   alarm_sequencer #(
      .TONE_HALF      (TH),
      .BEEP_HALF      (BH),
      .SNOOZE_S       (SNS),
      .RING_TIMEOUT_S (RTO),
      .MAX_SNOOZE     (MAXS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .tick_1hz      (tick_1hz),
      .hours         (h),
      .minutes       (m),
      .alarm_hours   (ah),
      .alarm_minutes (am),
      .alarm_enable  (en),
      .edit_active   (ed),
      .snooze_btn    (sb),
      .stop_btn      (st),
      .speaker       (speaker),
      .ringing       (ringing),
      .snoozed       (snoozed),
      .snooze_cnt    (snooze_cnt)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Alarm rules applied to the inputs held across the last clock edge
   task automatic model_edge();
      bit mt, trig, spk_n;
      int nm;
      mt   = en && !ed && (h == ah) && (m == am);
      trig = mt && !m_pm;
      if (reset) begin
         md = M_IDLE; m_cnt = 0; m_rt = 0; m_sl = 0; m_age = 0;
         m_pm = 0; m_sbp = 0; m_stp = 0; m_sbe = 0; m_ste = 0;
         m_spk = 0;
         return;
      end
      spk_n = (md == M_RING) && ((m_age / TH) % 2 == 0)
            && ((m_age / BH) % 2 == 0);
      nm = md;
      if (!en) begin
         nm = M_IDLE;
         m_cnt = 0;
      end else begin
         case (md)
            M_IDLE: if (trig) begin nm = M_RING; m_cnt = 0; end
            M_RING: begin
               if (m_ste) nm = M_DONE;
               else if (m_sbe && m_cnt < MAXS) begin
                  nm = M_SNZ; m_cnt++; m_sl = SNS;
               end else if (tick_1hz) begin
                  m_rt++;
                  if (m_rt >= RTO) nm = M_DONE;
               end
            end
            M_SNZ: begin
               if (m_ste) nm = M_DONE;
               else if (tick_1hz) begin
                  m_sl--;
                  if (m_sl <= 0) nm = M_RING;
               end
            end
            default: if (!mt) nm = M_IDLE;
         endcase
      end
      if (nm == M_RING && md != M_RING) begin
         m_age = 0; m_rt = 0;
      end else if (nm == M_RING) begin
         m_age++;
      end
      md = nm;
      m_spk = spk_n;
      m_pm = mt;
      m_sbe = sb && !m_sbp; m_sbp = sb;
      m_ste = st && !m_stp; m_stp = st;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      model_edge();
      chk("m_ringing", ringing, (md == M_RING));
      chk("m_snoozed", snoozed, (md == M_SNZ));
      chk("m_cnt", snooze_cnt, m_cnt);
      chk("m_speaker", speaker, m_spk);
      if (tick_auto) begin
         tick_ctr = (tick_ctr + 1) % 20;
         tick_1hz = (tick_ctr == 19);
      end
   endtask

   task automatic wait_ring(logic want, int bound, string tag);
      int n = 0;
      while (ringing !== want && n < bound) begin
         cyc();
         n++;
      end
      chk(tag, ringing, want);
   endtask

   initial begin
      int ones;
      reset = 1; tick_1hz = 0; en = 1; ed = 0; sb = 0; st = 0;
      h = 7; m = 29; ah = 7; am = 30;
      repeat (3) cyc();
      reset = 0;
      repeat (2) cyc();
      chk("rst_ringing", ringing, 0);
      chk("rst_speaker", speaker, 0);
      chk("rst_cnt", snooze_cnt, 0);

      // trigger and tone pattern
      m = 30; cyc();
      chk("trig_ringing", ringing, 1);
      chk("trig_spk_lat", speaker, 0);
      cyc();
      chk("trig_speaker", speaker, 1);
      ones = 1;
      for (int i = 1; i < 32; i++) begin
         cyc();
         ones += speaker;
      end
      chk("tone_duty", ones, 8);

      // timeout, no retrigger, rearm
      wait_ring(0, 200, "timeout");
      chk("timeout_snz", snoozed, 0);
      repeat (10) cyc();
      chk("no_retrig", ringing, 0);
      m = 31; cyc();
      m = 30; cyc();
      chk("rearm", ringing, 1);

      // snooze sequence
      sb = 1; cyc(); cyc();
      chk("snz1_state", snoozed, 1);
      chk("snz1_cnt", snooze_cnt, 1);
      chk("snz1_ring", ringing, 0);
      sb = 0;
      wait_ring(1, 100, "snz1_expire");
      sb = 1; cyc(); cyc();
      chk("snz2_cnt", snooze_cnt, 2);
      chk("snz2_state", snoozed, 1);
      sb = 0;
      wait_ring(1, 100, "snz2_expire");
      sb = 1; cyc(); cyc();
      chk("snz3_ignored", ringing, 1);
      chk("snz3_cnt", snooze_cnt, 2);
      sb = 0;
      st = 1; cyc(); cyc();
      chk("stop_ring", ringing, 0);
      cyc();
      chk("stop_spk", speaker, 0);
      st = 0; m = 31; cyc(); cyc();

      // stop and snooze together
      m = 30; cyc();
      chk("c_trig", ringing, 1);
      sb = 1; st = 1; cyc(); cyc();
      chk("c_ring", ringing, 0);
      chk("c_snz", snoozed, 0);
      chk("c_cnt", snooze_cnt, 0);
      sb = 0; st = 0; m = 31; cyc(); cyc();

      // stop during snooze
      m = 30; cyc();
      sb = 1; cyc(); cyc();
      chk("d_snz", snoozed, 1);
      sb = 0; st = 1; cyc(); cyc();
      chk("d_snz_off", snoozed, 0);
      chk("d_ring", ringing, 0);
      chk("d_cnt", snooze_cnt, 1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("d_spk", speaker, 0);
      end
      st = 0; m = 31; cyc(); cyc();

      // disarm while ringing
      m = 30; cyc(); cyc(); cyc();
      chk("e_ring", ringing, 1);
      en = 0; cyc();
      chk("e_ring_off", ringing, 0);
      cyc();
      chk("e_spk", speaker, 0);
      chk("e_cnt", snooze_cnt, 0);
      m = 31; cyc();
      en = 1; cyc();

      // reset while snoozing
      m = 30; cyc();
      sb = 1; cyc(); cyc();
      chk("f_snz", snoozed, 1);
      sb = 0; reset = 1; cyc();
      chk("f_snz_off", snoozed, 0);
      chk("f_ring", ringing, 0);
      chk("f_cnt", snooze_cnt, 0);
      chk("f_spk", speaker, 0);
      reset = 0; m = 31; cyc(); cyc();

      // edit suppression
      ed = 1; m = 29; cyc();
      m = 30;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("g_edit", ringing, 0);
      end
      m = 31; cyc();
      ed = 0; cyc();

      // random stimulus against the model
      tick_auto = 0;
      for (int i = 0; i < 4000; i++) begin
         tick_1hz = ($urandom % 12 == 0);
         if ($urandom % 8 == 0)   sb = ~sb;
         if ($urandom % 40 == 0)  st = ~st;
         en = ($urandom % 300 != 0);
         if ($urandom % 60 == 0)  ed = ~ed;
         if ($urandom % 40 == 0)  m = 6'(29 + $urandom % 3);
         if ($urandom % 400 == 0) am = 6'(29 + $urandom % 3);
         reset = ($urandom % 700 == 0);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
